turbo_frame_packer: RTL
=======================

Name: turbo_frame_packer

Overview:
- Upstream feeder for the turbo decoder.
- Accepts channel soft samples one symbol triple at a time (systematic, parity1, parity2) and quantizes each to 4-bit signed with symmetric saturation.
- Buffers one 7-symbol frame (5 info + 2 tail) in a ping-pong bank pair.
- Emits each frame as four 21-bit bit-plane words with a start strobe, then waits for the decoder's done pulse before releasing the bank.

Parameters:
- IN_W, 6, width of signed input soft samples
- QSHIFT, 1, arithmetic right shift applied before saturation
- FRAME_SYM, 7, symbols per frame including tail
- INFO_SYM, 5, information symbols per frame

Ports:
- clk_p_i  input  1  clock
- reset_n_i  input  1  reset
- in_valid_i  input  1  input triple valid
- in_ready_o  output  1  packer can accept a triple
- sys_i  input  IN_W  signed systematic soft value
- par1_i  input  IN_W  signed parity-1 soft value
- par2_i  input  IN_W  signed parity-2 soft value
- data_o  output  21  bit-plane word to decoder
- start_o  output  1  frame strobe to decoder
- dec_done_i  input  1  decoder done, rising edge significant
- sat_o  output  1  sticky: any sample saturated
- busy_o  output  1  a bank is full or emission/wait in progress

Behaviour:
- Clock and reset: clock clk_p_i; reset reset_n_i, asynchronous, active-low.
- Reset values: data_o=0, start_o=0, sat_o=0, busy_o=0, in_ready_o=1. Reset also clears banks, pointers and counters and returns the FSM to O_IDLE, aborting any emission mid-frame.
- Handshake: a transfer occurs when in_valid_i && in_ready_o. in_ready_o = !bank_full[wr_bank], derived from registered flags only.
- Quantization:
  - q = sample >>> QSHIFT.
  - q > 7 gives 7; q < -7 gives -7 (never -8, because the decoder negates).
  - Any clamp sets sat_o until reset.
- Filling:
  - Symbol counter sidx runs 0..FRAME_SYM-1 and stores the triple at index sidx of wr_bank.
  - On acceptance of index FRAME_SYM-1: set bank_full[wr_bank], toggle wr_bank, sidx=0.
- Output FSM, with data_o and start_o registered:
  - O_IDLE: if bank_full[rd_bank], go to O_EMIT with plane=0.
  - O_EMIT (4 cycles, plane 0..3, LSB plane first): start_o=1.
    - data_o[20-i] = bit[plane] of sys symbol i.
    - data_o[13-i] = bit[plane] of par1 symbol i.
    - data_o[6-i] = bit[plane] of par2 symbol i, for i=0..6.
  - O_HOLD: 1 cycle, start_o=1, data_o=0. Covers the decoder's extra sampling cycle.
  - O_WAIT: start_o=0, data_o=0. On dec_done_i rising edge (registered copy 0, current 1): clear bank_full[rd_bank], toggle rd_bank, go to O_IDLE.
    - A level held high produces no further releases.
    - An edge seen outside O_WAIT is ignored.
- Latency: last triple accepted at cycle T → plane-0 word on data_o at T+2. The start_o high window is exactly 5 cycles.
- Simultaneous events: filling one bank while the other is released is legal. A freed bank is visible on in_ready_o on the next cycle. Both banks full means in_ready_o=0.
- busy_o = bank_full != 0 || state != O_IDLE.

Optional Feature:
- Macro: TURBO_PACKER_TAIL_GEN_EN.
- Defined:
  - Only INFO_SYM triples are accepted per frame.
  - Symbols INFO_SYM..FRAME_SYM-1 are written 0 by hardware in the same cycle the last info triple is accepted; the bank is marked full then.
- Undefined: all FRAME_SYM triples, tail included, come from the input.

Decomposition:
- Shared package turbo_pkg:
  - LLR4_MAX=7, LLR4_MIN=-7
  - plane count 4
  - word field offsets SYS_MSB=20, PAR1_MSB=13, PAR2_MSB=6
  - output-state enum {O_IDLE, O_EMIT, O_HOLD, O_WAIT}
- Sub-module llr_quant_sat: one IN_W-to-4 quantizer with a sat flag, instantiated three times.

Test Plan:
- Quantize and plane order: sys0=10, all else 0 (7 triples), QSHIFT=1, so sys0 quantizes to 5.
  - Plane words bit20 = 1,0,1,0 for planes 0..3; all other bits 0.
  - start_o high 5 cycles; first word at T+2.
- Saturation: sys0=31, par1_0=-32.
  - sys0 → 7: bit20=1 on planes 0,1,2, 0 on plane 3.
  - par1_0 → -7 (1001): bit13 = 1,0,0,1.
  - sat_o=1 and stays 1.
- Ping-pong: 14 triples back-to-back with no dec_done_i.
  - Frame A emitted; in_ready_o=0 after the 14th.
  - A dec_done_i pulse releases A; frame B emitted 1 cycle later; in_ready_o=1 on the following cycle.
- Done level: dec_done_i held high.
  - Exactly one release; the next frame waits for a fresh 0→1.
- Reset mid-emission: assert reset_n_i during plane 2.
  - data_o=0, start_o=0, busy_o=0, in_ready_o=1 immediately.
  - The next full frame is emitted from plane 0.
- TURBO_PACKER_TAIL_GEN_EN: 5 triples of sys=par1=par2=14 (quantized 7).
  - Emission starts after the 5th triple.
  - Field bits for symbols 5,6 are 0 on all planes; symbols 0..4 are 1 on planes 0..2 and 0 on plane 3.

Source files
------------

// File: rtl/turbo_frame_packer_pkg.sv
// Shared constants and types for the turbo decoder frame packer.
package turbo_pkg;

   // 4-bit LLR range is symmetric because the decoder negates values.
   localparam int LLR4_MAX = 7;
   localparam int LLR4_MIN = -7;

   localparam int PLANES   = 4;
   localparam int WORD_W   = 21;
   localparam int SYS_MSB  = 20;
   localparam int PAR1_MSB = 13;
   localparam int PAR2_MSB = 6;

   typedef enum logic [1:0] {
      O_IDLE,
      O_EMIT,
      O_HOLD,
      O_WAIT
   } ostate_t;

endpackage

// File: rtl/turbo_frame_packer_if.sv
// Input triple handshake and decoder-side bus of the frame packer.
interface turbo_frame_packer_if
   import turbo_pkg::*;
#(
   parameter int IN_W = 6
) ();

   logic                   in_valid_i;
   logic                   in_ready_o;
   logic signed [IN_W-1:0] sys_i;
   logic signed [IN_W-1:0] par1_i;
   logic signed [IN_W-1:0] par2_i;
   logic [WORD_W-1:0]      data_o;
   logic                   start_o;
   logic                   dec_done_i;

   modport slave (
      input  in_valid_i, sys_i, par1_i, par2_i, dec_done_i,
      output in_ready_o, data_o, start_o
   );

   modport master (
      output in_valid_i, sys_i, par1_i, par2_i, dec_done_i,
      input  in_ready_o, data_o, start_o
   );

endinterface

// File: rtl/turbo_frame_packer_quant.sv
// llr_quant_sat: arithmetic shift then symmetric clamp to a 4-bit LLR.
module llr_quant_sat
   import turbo_pkg::*;
#(
   parameter int IN_W   = 6,
   parameter int QSHIFT = 1
) (
   input  logic signed [IN_W-1:0] sample,
   output logic        [3:0]      q,
   output logic                   sat
);

   localparam logic signed [IN_W-1:0] QMAX = IN_W'(LLR4_MAX);
   localparam logic signed [IN_W-1:0] QMIN = IN_W'(LLR4_MIN);

   logic signed [IN_W-1:0] shifted;

   // Shift down, then clamp into [-7, 7] and flag any clamp.
   always_comb begin
      shifted = sample >>> QSHIFT;
      sat     = 1'b0;
      q       = shifted[3:0];
      if (shifted > QMAX) begin
         q   = 4'(LLR4_MAX);
         sat = 1'b1;
      end else if (shifted < QMIN) begin
         q   = 4'(LLR4_MIN);
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/turbo_frame_packer.sv
// turbo_frame_packer: quantizes symbol triples into a ping-pong bank pair and
// emits each full frame as four bit-plane words to the turbo decoder.
// Optional build macro TURBO_PACKER_TAIL_GEN_EN: only INFO_SYM triples are
// taken per frame and the tail symbols are written as zero by hardware.
module turbo_frame_packer
   import turbo_pkg::*;
#(
   parameter int IN_W      = 6,
   parameter int QSHIFT    = 1,
   parameter int FRAME_SYM = 7,
   parameter int INFO_SYM  = 5
) (
   input  logic                 clk_p_i,
   input  logic                 reset_n_i,
   turbo_frame_packer_if.slave  bus,
   output logic                 sat_o,
   output logic                 busy_o
);

`ifdef TURBO_PACKER_TAIL_GEN_EN
   localparam bit TAIL_GEN = 1'b1;
`else
   localparam bit TAIL_GEN = 1'b0;
`endif
   localparam int SIDX_W   = (FRAME_SYM > 1) ? $clog2(FRAME_SYM) : 1;
   localparam int LAST_IDX = TAIL_GEN ? INFO_SYM - 1 : FRAME_SYM - 1;

   logic [3:0]        sys_mem  [2][FRAME_SYM];
   logic [3:0]        par1_mem [2][FRAME_SYM];
   logic [3:0]        par2_mem [2][FRAME_SYM];
   logic [1:0]        bank_full, full_d;
   logic              wr_bank, rd_bank;
   logic [SIDX_W-1:0] sidx;
   ostate_t           state, state_d;
   logic [1:0]        plane, plane_d, sel_plane;
   logic [WORD_W-1:0] word, data_d;
   logic              start_d, done_q, release_bank;
   logic              accept, last_sym;
   logic [3:0]        q_sys, q_par1, q_par2;
   logic              s_sys, s_par1, s_par2;

   llr_quant_sat #(.IN_W(IN_W), .QSHIFT(QSHIFT)) u_q_sys  (.sample(bus.sys_i),  .q(q_sys),  .sat(s_sys));
   llr_quant_sat #(.IN_W(IN_W), .QSHIFT(QSHIFT)) u_q_par1 (.sample(bus.par1_i), .q(q_par1), .sat(s_par1));
   llr_quant_sat #(.IN_W(IN_W), .QSHIFT(QSHIFT)) u_q_par2 (.sample(bus.par2_i), .q(q_par2), .sat(s_par2));

   assign bus.in_ready_o = !bank_full[wr_bank];
   assign accept         = bus.in_valid_i && bus.in_ready_o;
   assign last_sym       = (sidx == SIDX_W'(LAST_IDX));
   assign busy_o         = (bank_full != '0) || (state != O_IDLE);
   // Registered outputs are loaded with the word for the plane about to be shown.
   assign sel_plane      = (state == O_EMIT) ? plane + 2'd1 : 2'd0;

   // Write side: store quantized triples, close the frame on its last symbol.
   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned j = 0; j < FRAME_SYM; j++) begin
               sys_mem[b][j]  <= '0;
               par1_mem[b][j] <= '0;
               par2_mem[b][j] <= '0;
            end
         end
         sidx    <= '0;
         wr_bank <= 1'b0;
         sat_o   <= 1'b0;
      end else if (accept) begin
         sys_mem[wr_bank][sidx]  <= q_sys;
         par1_mem[wr_bank][sidx] <= q_par1;
         par2_mem[wr_bank][sidx] <= q_par2;
         sat_o <= sat_o | s_sys | s_par1 | s_par2;
         if (last_sym) begin
            sidx    <= '0;
            wr_bank <= ~wr_bank;
            if (TAIL_GEN) begin
               for (int unsigned j = INFO_SYM; j < FRAME_SYM; j++) begin
                  sys_mem[wr_bank][j]  <= '0;
                  par1_mem[wr_bank][j] <= '0;
                  par2_mem[wr_bank][j] <= '0;
               end
            end
         end else begin
            sidx <= sidx + 1'b1;
         end
      end
   end

   // Bit-plane word of the read bank for the selected plane.
   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < FRAME_SYM; i++) begin
         word[SYS_MSB - i]  = sys_mem[rd_bank][i][sel_plane];
         word[PAR1_MSB - i] = par1_mem[rd_bank][i][sel_plane];
         word[PAR2_MSB - i] = par2_mem[rd_bank][i][sel_plane];
      end
   end

   // Output FSM next state, next registered outputs and bank flag updates.
   always_comb begin
      state_d      = state;
      plane_d      = plane;
      data_d       = '0;
      start_d      = 1'b0;
      release_bank = 1'b0;
      full_d       = bank_full;
      case (state)
         O_IDLE: begin
            if (bank_full[rd_bank]) begin
               state_d = O_EMIT;
               plane_d = 2'd0;
               data_d  = word;
               start_d = 1'b1;
            end
         end
         O_EMIT: begin
            start_d = 1'b1;
            if (plane == 2'(PLANES - 1)) begin
               state_d = O_HOLD;
            end else begin
               plane_d = plane + 2'd1;
               data_d  = word;
            end
         end
         O_HOLD: state_d = O_WAIT;
         O_WAIT: begin
            if (bus.dec_done_i && !done_q) begin
               release_bank = 1'b1;
               state_d      = O_IDLE;
            end
         end
         default: state_d = O_IDLE;
      endcase
      // Release and fill always target different banks, so both may apply.
      if (release_bank) full_d[rd_bank] = 1'b0;
      if (accept && last_sym) full_d[wr_bank] = 1'b1;
   end

   // Read side state, registered outputs and bank flags.
   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state       <= O_IDLE;
         plane       <= 2'd0;
         bus.data_o  <= '0;
         bus.start_o <= 1'b0;
         rd_bank     <= 1'b0;
         bank_full   <= '0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_d;
         plane       <= plane_d;
         bus.data_o  <= data_d;
         bus.start_o <= start_d;
         bank_full   <= full_d;
         done_q      <= bus.dec_done_i;
         if (release_bank) rd_bank <= ~rd_bank;
      end
   end

endmodule
